// File: rtl/fifo_reader.sv
// Read-side controller for the single-port-access FIFO: issues read strobes,
// captures registered read data into a 2-entry skid buffer and streams it out.
module fifo_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ENABLE,
  input  logic                  FIFO_EMPTY,
  input  logic                  FIFO_WR_EN,
  input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
  output logic                  FIFO_RD_EN,
  output logic                  WR_HOLD,
  output logic                  M_VALID,
  output logic [DATA_WIDTH-1:0] M_DATA,
  input  logic                  M_READY,
  output logic                  BUSY,
  output logic [CNT_WIDTH-1:0]  XFER_COUNT
);

  localparam int BLK_W = 8;
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(STARVE_LIMIT);

  logic [1:0]            occ, occ_next;
  logic                  pend;
  logic [DATA_WIDTH-1:0] buf0, buf1, buf0_next, buf1_next;
  logic [BLK_W-1:0]      blk_cnt, blk_next;
  logic                  hold_next;
  logic [CNT_WIDTH-1:0]  xfer_cnt;
  logic [2:0]            committed;
  logic                  pop, want, rd_en, blocked;

  assign M_VALID    = (occ != 2'd0);
  assign M_DATA     = buf0;
  assign BUSY       = pend || (occ != 2'd0);
  assign XFER_COUNT = xfer_cnt;
  assign FIFO_RD_EN = rd_en;

  // Words already owed to the buffer (held + in flight) after this cycle's pop.
  always_comb begin
    pop       = M_VALID && M_READY;
    committed = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    want      = ENABLE && !FIFO_EMPTY && (committed < 3'd2);
    rd_en     = want && !FIFO_WR_EN && RST_N;
    blocked   = want && FIFO_WR_EN;
  end

  // Shift on pop, then append the in-flight word at the new tail.
  // buf1 is kept at zero whenever it is unoccupied so a shift clears the head.
  always_comb begin
    buf0_next = buf0;
    buf1_next = buf1;
    occ_next  = occ;
    if (pop) begin
      buf0_next = buf1;
      buf1_next = '0;
      occ_next  = occ - 2'd1;
    end
    if (pend) begin
      if (occ_next == 2'd0) begin
        buf0_next = FIFO_DOUT;
      end else begin
        buf1_next = FIFO_DOUT;
      end
      occ_next = occ_next + 2'd1;
    end
  end

  always_comb begin
    blk_next  = '0;
    hold_next = WR_HOLD;
    if (blocked) begin
      blk_next = (blk_cnt >= BLK_MAX) ? BLK_MAX : blk_cnt + 8'd1;
    end
    if (!ENABLE || rd_en) begin
      hold_next = 1'b0;
    end else if (blocked && (blk_next == BLK_MAX)) begin
      hold_next = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      occ      <= 2'd0;
      pend     <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
      blk_cnt  <= '0;
      WR_HOLD  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      occ      <= occ_next;
      pend     <= rd_en;
      buf0     <= buf0_next;
      buf1     <= buf1_next;
      blk_cnt  <= blk_next;
      WR_HOLD  <= hold_next;
      if (pop) begin
        xfer_cnt <= xfer_cnt + 1'b1;
      end
    end
  end

endmodule
